mul_scheduler: RTL and testbench
================================

# mul_scheduler

Sequencer for one shared iterative 16x16 multiplier, used in place of the two per-slot combinational multipliers in the execute stage. It takes multiply requests from EX slot 0 and slot 1 (the dual-issue pair) and serializes them, slot 0 first. It holds the pipeline with `stall` until every pending request in the pair has finished, then releases both 32-bit products in the same cycle for capture into EX/MEM.

## Interface
- `BITS_PER_CYCLE`, default 1: multiplier bits retired per iteration. Legal values are 1, 2 and 4. Number of ITER cycles per op: `N_ITER = 16/BITS_PER_CYCLE`.

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous abort; same priority as reset, except result registers are kept
- `req_0`  in  1  slot 0 holds a valid MUL-type instruction (UMULL or SMULL)
- `a_0`, `b_0`  in  16  slot 0 forwarded operands
- `signed_0`  in  1  slot 0 is SMULL
- `req_1`, `a_1`, `b_1`, `signed_1`  in  1/16/16/1  same fields for slot 1
- `stall`  out  1  hold IF/ID/EX; combinational
- `done_0`, `done_1`  out  1  product valid for that slot this cycle
- `result_lo_0`, `result_hi_0`, `result_lo_1`, `result_hi_1`  out  16  per-slot product halves, registered
- `busy`  out  1  state is not IDLE

## Operation
- States:
  - IDLE: waiting for a request.
  - ITER: shift-add. Each cycle adds `BITS_PER_CYCLE` partial products of |b| times |a| into a 32-bit accumulator, then shifts.
  - FIX: negates the accumulator if `signed` and sign(a)≠sign(b). Writes the slot's result registers and sets `served_x`.
  - DONE: release cycle.
- IDLE → ITER when `req_0` or `req_1` is high.
  - Captures the slot-0 operands if `req_0`, otherwise the slot-1 operands.
- ITER → FIX after `N_ITER` cycles.
- FIX → ITER if `req_1 && !served_1`. Slot-1 operands are captured at the end of FIX.
- FIX → DONE otherwise.
- DONE → IDLE unconditionally. `served_0` and `served_1` are cleared on this transition.
- Magnitude rule: |0x8000| = 0x8000 as unsigned 16-bit, so it needs no special case. When unsigned, operands are taken raw.
- `stall` = `(req_0 & !served_0) | (req_1 & !served_1)`, and is 0 while in DONE or while `rst` is high.
- `done_x` = (state==DONE) & `served_x`.
- Result registers hold their value until overwritten by a later FIX. EX/MEM samples them in the DONE cycle.
- Requests from the EX pair are stable while `stall` is high; the scheduler does not re-sample `req_x` mid-op.
- `flush` in any state:
  - next state is IDLE;
  - served flags are cleared;
  - `done_x` is low in the following cycle;
  - the in-flight product is discarded.
- Simultaneous `rst` and `flush`: reset wins.
- `flush` in the DONE cycle suppresses nothing already visible. `done_x` is still high in that cycle, and the state goes to IDLE.

## Timing
- Reset values: state IDLE, `stall`=0, `busy`=0, `done_0`=`done_1`=0, all results 0x0000, served flags 0.
- Single request first seen in cycle t:
  - `stall` high in t .. t+`N_ITER`+1;
  - ITER in t+1 .. t+`N_ITER`;
  - FIX in t+`N_ITER`+1;
  - DONE (done high, `stall` low) in t+`N_ITER`+2.
  - With `BITS_PER_CYCLE`=1, DONE is at t+18.
- Dual request in cycle t: DONE at t+2·(`N_ITER`+1)+1, i.e. t+35 for `BITS_PER_CYCLE`=1. `done_0` and `done_1` are high together.
- Next request can start at earliest the cycle after DONE, which is the back-to-back issue rate.
- Accumulator width is 32 bits. No overflow is possible (max unsigned 0xFFFE_0001).

## Configuration
- `NEOCORE_MUL_EARLY_OUT_EN` defined:
  - ITER exits to FIX as soon as the remaining unshifted |b| bits are zero, with a minimum of one ITER cycle.
  - Latency therefore depends on the data.
- `NEOCORE_MUL_EARLY_OUT_EN` undefined: always exactly `N_ITER` ITER cycles, so latency is fixed.

## Test plan
- Unsigned, slot 0 only: `req_0`=1, a=0x1234, b=0x5678, `BITS_PER_CYCLE`=1, request in cycle t.
  - Required: `done_0` at t+18, {hi,lo}=0x0626_0060.
  - `stall` high in exactly 18 cycles.
- Signed corners, one run per operand pair:
  - SMULL 0xFFFF×0x0001 → 0xFFFF_FFFF.
  - SMULL 0x8000×0x8000 → 0x4000_0000.
  - UMULL 0xFFFF×0xFFFF → 0xFFFE_0001.
- Dual issue: slot 0 UMULL 3×5 and slot 1 SMULL 0xFFFE×7, both requested in cycle t.
  - Required: `done_0`=`done_1`=1 at t+35.
  - Slot 0 product 0x0000_000F, slot 1 product 0xFFFF_FFF2.
- Flush mid-ITER: `flush` at t+5.
  - Required: IDLE at t+6, `busy`=0, no done pulse.
  - Results unchanged from their prior value.
  - A new request at t+6 completes at t+24.
- Early out with `NEOCORE_MUL_EARLY_OUT_EN` defined: UMULL 0x00FF×0x0001 in cycle t.
  - Required: DONE at t+3, product 0x0000_00FF.
  - With the macro undefined: DONE at t+18, same product.
- Reset during ITER: `rst` pulsed at t+4.
  - Required: all outputs return to their reset values at t+5, and `stall`=0 while `rst` is high.

Source files
------------

// File: rtl/mul_scheduler.sv
// Shared iterative 16x16 multiplier sequencer for the dual-issue EX pair (slot 0 first).
// Optional early-out on exhausted multiplier bits: define NEOCORE_MUL_EARLY_OUT_EN.
module mul_scheduler #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_0,
    input  logic [15:0] a_0,
    input  logic [15:0] b_0,
    input  logic        signed_0,
    input  logic        req_1,
    input  logic [15:0] a_1,
    input  logic [15:0] b_1,
    input  logic        signed_1,
    output logic        stall,
    output logic        done_0,
    output logic        done_1,
    output logic [15:0] result_lo_0,
    output logic [15:0] result_hi_0,
    output logic [15:0] result_lo_1,
    output logic [15:0] result_hi_1,
    output logic        busy
);

    localparam int N_ITER = 16 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic        slot_q, slot_d;
    logic        served0_q, served0_d;
    logic        served1_q, served1_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res0_q, res0_d;
    logic [31:0] res1_q, res1_d;

    logic        cap_slot1;
    logic [15:0] cap_a, cap_b;
    logic        cap_signed;
    logic [15:0] mag_a, mag_b;
    logic [31:0] pp_sum;
    logic [15:0] mplier_next;
    logic        last_iter;
    logic [31:0] prod_fixed;

    // Operand capture: IDLE takes slot 0 when it requests, FIX always moves on to slot 1.
    always_comb begin
        cap_slot1  = (state_q == S_FIX) || !req_0;
        cap_a      = cap_slot1 ? a_1 : a_0;
        cap_b      = cap_slot1 ? b_1 : b_0;
        cap_signed = cap_slot1 ? signed_1 : signed_0;
        mag_a      = (cap_signed && cap_a[15]) ? (~cap_a + 16'd1) : cap_a;
        mag_b      = (cap_signed && cap_b[15]) ? (~cap_b + 16'd1) : cap_b;
    end

    always_comb begin
        pp_sum = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                pp_sum = pp_sum + (mcand_q << k);
            end
        end
        mplier_next = mplier_q >> BITS_PER_CYCLE;
`ifdef NEOCORE_MUL_EARLY_OUT_EN
        last_iter = (cnt_q == 5'(N_ITER - 1)) || (mplier_next == 16'd0);
`else
        last_iter = (cnt_q == 5'(N_ITER - 1));
`endif
        prod_fixed = neg_q ? (~acc_q + 32'd1) : acc_q;
    end

    // Next-state logic; flush overrides the case result but leaves the result registers alone.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        slot_d    = slot_q;
        served0_d = served0_q;
        served1_d = served1_q;
        cnt_d     = cnt_q;
        res0_d    = res0_q;
        res1_d    = res1_q;

        case (state_q)
            S_IDLE: begin
                if (req_0 || req_1) begin
                    state_d  = S_ITER;
                    acc_d    = '0;
                    mcand_d  = {16'd0, mag_a};
                    mplier_d = mag_b;
                    neg_d    = cap_signed && (cap_a[15] ^ cap_b[15]);
                    slot_d   = cap_slot1;
                    cnt_d    = '0;
                end
            end
            S_ITER: begin
                acc_d    = acc_q + pp_sum;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_next;
                cnt_d    = cnt_q + 5'd1;
                if (last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (slot_q) begin
                    res1_d    = prod_fixed;
                    served1_d = 1'b1;
                end else begin
                    res0_d    = prod_fixed;
                    served0_d = 1'b1;
                end
                if (req_1 && !served1_d) begin
                    state_d  = S_ITER;
                    acc_d    = '0;
                    mcand_d  = {16'd0, mag_a};
                    mplier_d = mag_b;
                    neg_d    = cap_signed && (cap_a[15] ^ cap_b[15]);
                    slot_d   = 1'b1;
                    cnt_d    = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                served0_d = 1'b0;
                served1_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d   = S_IDLE;
            served0_d = 1'b0;
            served1_d = 1'b0;
            res0_d    = res0_q;
            res1_d    = res1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            slot_q    <= 1'b0;
            served0_q <= 1'b0;
            served1_q <= 1'b0;
            cnt_q     <= '0;
            res0_q    <= '0;
            res1_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            slot_q    <= slot_d;
            served0_q <= served0_d;
            served1_q <= served1_d;
            cnt_q     <= cnt_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
        end
    end

    assign stall = !rst && (state_q != S_DONE) &&
                   ((req_0 && !served0_q) || (req_1 && !served1_q));
    assign done_0      = (state_q == S_DONE) && served0_q;
    assign done_1      = (state_q == S_DONE) && served1_q;
    assign busy        = (state_q != S_IDLE);
    assign result_lo_0 = res0_q[15:0];
    assign result_hi_0 = res0_q[31:16];
    assign result_lo_1 = res1_q[15:0];
    assign result_hi_1 = res1_q[31:16];

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed self-checking bench for mul_scheduler (BITS_PER_CYCLE=1).
// Latency expectations follow NEOCORE_MUL_EARLY_OUT_EN when it is defined.
module tb_mul_scheduler;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        req_0, signed_0, req_1, signed_1;
    logic [15:0] a_0, b_0, a_1, b_1;
    logic        stall, done_0, done_1, busy;
    logic [15:0] result_lo_0, result_hi_0, result_lo_1, result_hi_1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_scheduler #(.BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_0(req_0), .a_0(a_0), .b_0(b_0), .signed_0(signed_0),
        .req_1(req_1), .a_1(a_1), .b_1(b_1), .signed_1(signed_1),
        .stall(stall), .done_0(done_0), .done_1(done_1),
        .result_lo_0(result_lo_0), .result_hi_0(result_hi_0),
        .result_lo_1(result_lo_1), .result_hi_1(result_hi_1),
        .busy(busy)
    );

    // ITER cycles one op needs: 16 normally, bit length of |b| (min 1) with early-out.
    function automatic int iterCount(input logic [15:0] b, input logic s);
`ifdef NEOCORE_MUL_EARLY_OUT_EN
        logic [15:0] m;
        int n;
        m = (s && b[15]) ? (~b + 16'd1) : b;
        n = 1;
        for (int i = 0; i < 16; i++) if (m[i]) n = i + 1;
        return n;
`else
        if (s && b[15]) return 16;
        return 16;
`endif
    endfunction

    task automatic applyStimulus(input logic r0, input logic [15:0] x0, input logic [15:0] y0,
                                 input logic s0, input logic r1, input logic [15:0] x1,
                                 input logic [15:0] y1, input logic s1);
        @(posedge clk); #1;
        req_0 = r0; a_0 = x0; b_0 = y0; signed_0 = s0;
        req_1 = r1; a_1 = x1; b_1 = y1; signed_1 = s1;
        #1;
    endtask

    task automatic releaseReq();
        @(posedge clk); #1;
        req_0 = 1'b0; req_1 = 1'b0;
        #1;
    endtask

    // Cycle 0 is the current cycle; returns the cycle offset of the first done pulse.
    task automatic waitDone(output int doneAt, output int stallCnt, output logic d0,
                            output logic d1, output logic [31:0] p0, output logic [31:0] p1);
        doneAt = -1; stallCnt = 0; d0 = 0; d1 = 0; p0 = '0; p1 = '0;
        for (int c = 0; c < 80; c++) begin
            if (stall) stallCnt++;
            if (done_0 || done_1) begin
                doneAt = c; d0 = done_0; d1 = done_1;
                p0 = {result_hi_0, result_lo_0};
                p1 = {result_hi_1, result_lo_1};
                break;
            end
            @(posedge clk); #2;
        end
        if (doneAt < 0) begin
            checks++; errors++;
            $display("[TB] FAIL timeout: no done pulse within 80 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        req_0 = 1'b1; a_0 = 16'h1111; b_0 = 16'h2222; signed_0 = 1'b0;
        req_1 = 1'b0; a_1 = '0; b_1 = '0; signed_1 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++;
        if ({busy, done_0, done_1} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_flags: busy/done0/done1 got %b expected 000", {busy, done_0, done_1});
        end
        checks++;
        if ({result_hi_0, result_lo_0, result_hi_1, result_lo_1} !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_results: got %h expected 0",
                               {result_hi_0, result_lo_0, result_hi_1, result_lo_1});
        end
        req_0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_unsigned();
        int d, s, expLat;
        logic d0, d1;
        logic [31:0] p0, p1;
        expLat = iterCount(16'h5678, 1'b0) + 2;
        applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, '0, '0, 1'b0);
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (d !== expLat) begin errors++; $display("[TB] FAIL unsigned_latency: got %0d expected %0d", d, expLat); end
        checks++;
        if (s !== expLat) begin errors++; $display("[TB] FAIL unsigned_stall_cycles: got %0d expected %0d", s, expLat); end
        checks++;
        if ({d0, d1} !== 2'b10) begin errors++; $display("[TB] FAIL unsigned_done_flags: got %b expected 10", {d0, d1}); end
        checks++;
        if (p0 !== 32'h0626_0060) begin errors++; $display("[TB] FAIL unsigned_product: got %h expected 06260060", p0); end
        releaseReq();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL unsigned_idle_after: busy got %b expected 0", busy); end
    endtask

    task automatic test_signed_corners();
        logic [15:0] ta [3] = '{16'hFFFF, 16'h8000, 16'hFFFF};
        logic [15:0] tbv[3] = '{16'h0001, 16'h8000, 16'hFFFF};
        logic        ts [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] tp [3] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'hFFFE_0001};
        int d, s, expLat;
        logic d0, d1;
        logic [31:0] p0, p1;
        for (int i = 0; i < 3; i++) begin
            expLat = iterCount(tbv[i], ts[i]) + 2;
            applyStimulus(1'b1, ta[i], tbv[i], ts[i], 1'b0, '0, '0, 1'b0);
            waitDone(d, s, d0, d1, p0, p1);
            checks++;
            if (d !== expLat) begin errors++; $display("[TB] FAIL corner%0d_latency: got %0d expected %0d", i, d, expLat); end
            checks++;
            if (p0 !== tp[i]) begin errors++; $display("[TB] FAIL corner%0d_product: got %h expected %h", i, p0, tp[i]); end
            releaseReq();
        end
    endtask

    task automatic test_dual();
        int d, s, expLat;
        logic d0, d1;
        logic [31:0] p0, p1;
        expLat = iterCount(16'h0005, 1'b0) + iterCount(16'h0007, 1'b1) + 3;
        applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 16'h0007, 1'b1);
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (d !== expLat) begin errors++; $display("[TB] FAIL dual_latency: got %0d expected %0d", d, expLat); end
        checks++;
        if ({d0, d1} !== 2'b11) begin errors++; $display("[TB] FAIL dual_done_flags: got %b expected 11", {d0, d1}); end
        checks++;
        if (p0 !== 32'h0000_000F) begin errors++; $display("[TB] FAIL dual_product0: got %h expected 0000000f", p0); end
        checks++;
        if (p1 !== 32'hFFFF_FFF2) begin errors++; $display("[TB] FAIL dual_product1: got %h expected fffffff2", p1); end
        checks++;
        if (s !== expLat) begin errors++; $display("[TB] FAIL dual_stall_cycles: got %0d expected %0d", s, expLat); end
        releaseReq();

        expLat = iterCount(16'h0004, 1'b0) + 2;
        applyStimulus(1'b0, 16'h7777, 16'h7777, 1'b0, 1'b1, 16'h0003, 16'h0004, 1'b0);
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (d !== expLat) begin errors++; $display("[TB] FAIL slot1_latency: got %0d expected %0d", d, expLat); end
        checks++;
        if ({d0, d1} !== 2'b01) begin errors++; $display("[TB] FAIL slot1_done_flags: got %b expected 01", {d0, d1}); end
        checks++;
        if (p1 !== 32'h0000_000C) begin errors++; $display("[TB] FAIL slot1_product: got %h expected 0000000c", p1); end
        checks++;
        if (p0 !== 32'h0000_000F) begin errors++; $display("[TB] FAIL slot1_keeps_slot0: got %h expected 0000000f", p0); end
        releaseReq();
    endtask

    task automatic test_back_to_back();
        int d, s, expLat;
        logic d0, d1;
        logic [31:0] p0, p1;
        applyStimulus(1'b1, 16'h0010, 16'h0010, 1'b0, 1'b0, '0, '0, 1'b0);
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (p0 !== 32'h0000_0100) begin errors++; $display("[TB] FAIL b2b_first_product: got %h expected 00000100", p0); end
        // Second op presented in the cycle right after DONE, request kept high.
        expLat = iterCount(16'h0100, 1'b0) + 2;
        @(posedge clk); #1;
        a_0 = 16'h0100; b_0 = 16'h0100;
        #1;
        checks++;
        if (stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart_stall: got %b expected 1", stall); end
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (d !== expLat) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", d, expLat); end
        checks++;
        if (p0 !== 32'h0001_0000) begin errors++; $display("[TB] FAIL b2b_second_product: got %h expected 00010000", p0); end
        releaseReq();
    endtask

    task automatic test_flush();
        int d, s, expLat, pulses;
        logic d0, d1;
        logic [31:0] p0, p1;
        pulses = 0;
        applyStimulus(1'b1, 16'h00AB, 16'h00CD, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            if (done_0 || done_1) pulses++;
            @(posedge clk); #1;
            if (i == 5) flush = 1'b1;
            #1;
        end
        if (done_0 || done_1) pulses++;
        @(posedge clk); #1;
        flush = 1'b0;
        a_0 = 16'h0002; b_0 = 16'h0003;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
        checks++;
        if ({done_0, done_1} !== 2'b00 || pulses != 0) begin
            errors++; $display("[TB] FAIL flush_no_done: got done=%b pulses=%0d expected 00/0", {done_0, done_1}, pulses);
        end
        checks++;
        if ({result_hi_0, result_lo_0} !== 32'h0001_0000 || {result_hi_1, result_lo_1} !== 32'h0000_000C) begin
            errors++; $display("[TB] FAIL flush_results_kept: got %h %h expected 00010000 0000000c",
                               {result_hi_0, result_lo_0}, {result_hi_1, result_lo_1});
        end
        expLat = iterCount(16'h0003, 1'b0) + 2;
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (d !== expLat) begin errors++; $display("[TB] FAIL flush_restart_latency: got %0d expected %0d", d, expLat); end
        checks++;
        if (p0 !== 32'h0000_0006) begin errors++; $display("[TB] FAIL flush_restart_product: got %h expected 00000006", p0); end
        releaseReq();
    endtask

    task automatic test_early_out();
        int d, s, expLat;
        logic d0, d1;
        logic [31:0] p0, p1;
`ifdef NEOCORE_MUL_EARLY_OUT_EN
        expLat = 3;
`else
        expLat = 18;
`endif
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, '0, '0, 1'b0);
        waitDone(d, s, d0, d1, p0, p1);
        checks++;
        if (d !== expLat) begin errors++; $display("[TB] FAIL early_out_latency: got %0d expected %0d", d, expLat); end
        checks++;
        if (p0 !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL early_out_product: got %h expected 000000ff", p0); end
        releaseReq();
    endtask

    task automatic checkOutput_resetMid();
        applyStimulus(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (stall !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_pre: stall/busy got %b%b expected 11", stall, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stall_during_rst: got %b expected 0", stall); end
        @(posedge clk); #1;
        rst = 1'b0; req_0 = 1'b0;
        #1;
        checks++;
        if ({stall, busy, done_0, done_1} !== 4'b0000) begin
            errors++; $display("[TB] FAIL rstmid_flags: got %b expected 0000", {stall, busy, done_0, done_1});
        end
        checks++;
        if ({result_hi_0, result_lo_0, result_hi_1, result_lo_1} !== 64'd0) begin
            errors++; $display("[TB] FAIL rstmid_results: got %h expected 0",
                               {result_hi_0, result_lo_0, result_hi_1, result_lo_1});
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed_corners();
        test_dual();
        test_back_to_back();
        test_flush();
        test_early_out();
        checkOutput_resetMid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
